// File: rtl/port_rr_scheduler_pkg.sv
// Shared types and constants for the packet-level round-robin port scheduler.
package port_sched_pkg;

   localparam int DEF_PORTNUM = 16;
   localparam int DEF_TIMEOUT = 1024;
   localparam int DEF_GAP     = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Width of a port index; never narrower than one bit.
   function automatic int port_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/port_rr_scheduler_if.sv
// Request/grant bundle between the per-port input buffers and the scheduler.
interface port_rr_scheduler_if #(
   parameter int PORTNUM = 16
);
   localparam int PORT_W = port_sched_pkg::port_w(PORTNUM);

   logic [PORTNUM-1:0] i_req;
   logic [PORTNUM-1:0] i_eop;
   logic [PORTNUM-1:0] i_mask;
   logic [PORTNUM-1:0] o_grant;
   logic [PORT_W-1:0]  o_sel;
   logic               o_port_ready;
   logic               o_timeout;
   logic [PORT_W-1:0]  o_timeout_port;

   modport master (
      output i_req, i_eop, i_mask,
      input  o_grant, o_sel, o_port_ready, o_timeout, o_timeout_port
   );

   modport slave (
      input  i_req, i_eop, i_mask,
      output o_grant, o_sel, o_port_ready, o_timeout, o_timeout_port
   );

endinterface

// File: rtl/port_rr_scheduler_pick.sv
// Combinational round-robin pick: first eligible port at or after rr_ptr, wrapping.
// Rotate so rr_ptr lands at bit 0, priority-encode the lowest set bit, add rr_ptr back.
module rr_prior_pick
   import port_sched_pkg::*;
#(
   parameter int PORTNUM = 16,
   parameter int PW      = port_w(PORTNUM)
) (
   input  logic [PORTNUM-1:0] eligible,
   input  logic [PW-1:0]      rr_ptr,
   output logic               pick_vld,
   output logic [PW-1:0]      pick_idx
);

   logic [2*PORTNUM-1:0] dbl;
   logic [PORTNUM-1:0]   rot;
   logic [PW-1:0]        off;
   logic [PW:0]          sum;

   always_comb begin
      dbl      = {eligible, eligible};
      rot      = PORTNUM'(dbl >> rr_ptr);
      off      = '0;
      pick_vld = 1'b0;
      for (int i = 0; i < PORTNUM; i++) begin
         if (rot[i] && !pick_vld) begin
            off      = PW'(i);
            pick_vld = 1'b1;
         end
      end
      sum = {1'b0, off} + {1'b0, rr_ptr};
      if (sum >= (PW+1)'(PORTNUM)) begin
         sum = sum - (PW+1)'(PORTNUM);
      end
      pick_idx = PW'(sum);
   end

endmodule

// File: rtl/port_rr_scheduler.sv
// Packet-level round-robin owner of the shared write path: 1-cycle request-to-grant,
// grant locked until eop of the owner or TIMEOUT cycles, then GAP idle cycles.
module port_rr_scheduler
   import port_sched_pkg::*;
#(
   parameter int PORTNUM = DEF_PORTNUM,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int GAP     = DEF_GAP
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   port_rr_scheduler_if.slave  sif
);

   localparam int PW = port_w(PORTNUM);
   localparam int CW = $clog2(TIMEOUT);
   localparam int GW = 3;

   state_t             state_q, state_d;
   logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [PORTNUM-1:0] grant_q, grant_d;
   logic [PW-1:0]      sel_q, sel_d;
   logic               ready_q, ready_d;
   logic               timeout_q, timeout_d;
   logic [PW-1:0]      to_port_q, to_port_d;
   logic [CW-1:0]      hold_cnt_q, hold_cnt_d;
   logic [GW-1:0]      gap_cnt_q, gap_cnt_d;

   logic [PORTNUM-1:0] eligible;
   logic               pick_vld;
   logic [PW-1:0]      pick_idx;
   logic               release_now;

   assign eligible = sif.i_req & sif.i_mask;

   rr_prior_pick #(.PORTNUM(PORTNUM), .PW(PW)) u_pick (
      .eligible (eligible),
      .rr_ptr   (rr_ptr_q),
      .pick_vld (pick_vld),
      .pick_idx (pick_idx)
   );

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      sel_d       = sel_q;
      ready_d     = ready_q;
      timeout_d   = 1'b0;
      to_port_d   = to_port_q;
      hold_cnt_d  = hold_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      release_now = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               grant_d    = PORTNUM'(1) << pick_idx;
               sel_d      = pick_idx;
               hold_cnt_d = '0;
               ready_d    = 1'b0;
               state_d    = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // eop wins over the budget check, so a packet ending exactly on budget is not a timeout.
            if (sif.i_eop[sel_q]) begin
               release_now = 1'b1;
            end else if (hold_cnt_q == CW'(TIMEOUT-1)) begin
               release_now = 1'b1;
               timeout_d   = 1'b1;
               to_port_d   = sel_q;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
            if (release_now) begin
               grant_d  = '0;
               rr_ptr_d = (sel_q == PW'(PORTNUM-1)) ? '0 : sel_q + 1'b1;
               if (GAP > 0) begin
                  gap_cnt_d = '0;
                  state_d   = ST_GAP;
               end else begin
                  ready_d = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GW'(GAP-1)) begin
               ready_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: begin
            grant_d = '0;
            ready_d = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         sel_q      <= '0;
         ready_q    <= 1'b1;
         timeout_q  <= 1'b0;
         to_port_q  <= '0;
         hold_cnt_q <= '0;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         sel_q      <= sel_d;
         ready_q    <= ready_d;
         timeout_q  <= timeout_d;
         to_port_q  <= to_port_d;
         hold_cnt_q <= hold_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   assign sif.o_grant        = grant_q;
   assign sif.o_sel          = sel_q;
   assign sif.o_port_ready   = ready_q;
   assign sif.o_timeout      = timeout_q;
   assign sif.o_timeout_port = to_port_q;

endmodule
